// File: rtl/com_pkg.sv
// Shared definitions for the com_tx / typec_rx transmit path:
// BAG codes, scheduler states and requester encodings.
package com_pkg;

  localparam logic [3:0] BAG_INIT   = 4'b0000;
  localparam logic [3:0] BAG_ACK    = 4'b0001;
  localparam logic [3:0] BAG_NAK    = 4'b0010;
  localparam logic [3:0] BAG_STALL  = 4'b0011;
  localparam logic [3:0] BAG_DIDX   = 4'b0101;
  localparam logic [3:0] BAG_DPARAM = 4'b0110;
  localparam logic [3:0] BAG_DDIDX  = 4'b0111;

  localparam logic [1:0] HS_ACK   = 2'd1;
  localparam logic [1:0] HS_NAK   = 2'd2;
  localparam logic [1:0] HS_STALL = 2'd3;

  localparam logic [1:0] CFG_DIDX   = 2'd0;
  localparam logic [1:0] CFG_DPARAM = 2'd1;
  localparam logic [1:0] CFG_DDIDX  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREP, ST_SEND, ST_WAIT, ST_READ, ST_EVAL, ST_DRAIN, ST_DONE
  } com_state_e;

  // Illegal handshake type 0 goes out as STALL.
  function automatic logic [3:0] hs_bag(input logic [1:0] t);
    case (t)
      HS_ACK:  return BAG_ACK;
      HS_NAK:  return BAG_NAK;
      default: return BAG_STALL;
    endcase
  endfunction

  // Illegal selector 3 goes out as DDIDX.
  function automatic logic [3:0] cfg_bag(input logic [1:0] s);
    case (s)
      CFG_DIDX:   return BAG_DIDX;
      CFG_DPARAM: return BAG_DPARAM;
      default:    return BAG_DDIDX;
    endcase
  endfunction

endpackage

// File: rtl/com_tmo_cnt.sv
// Reply timeout counter: synchronous clear has priority over enable,
// o_hit flags the last cycle of the TIMEOUT window.
module com_tmo_cnt
  import com_pkg::*;
#(
  parameter int TW      = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_hit = (r_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/com_tx_arb.sv
// Transmit scheduler for com_tx: arbitrates handshake vs config packets,
// collects the peer reply and retries config packets on NAK/timeout.
//
// state | meaning
// IDLE  | arbitrate: rx_fs > req_hs > req_cfg
// PREP  | register BAG code and selected payload field
// SEND  | tx_fs high until tx_fd
// WAIT  | cfg only: wait for reply or timeout
// READ  | consume reply, latch its BAG code
// EVAL  | ACK -> done, else retry or error
// DRAIN | consume unsolicited packet
// DONE  | one status pulse, back to IDLE
module com_tx_arb
  import com_pkg::*;
#(
  parameter int TIMEOUT   = 1000,
  parameter int MAX_RETRY = 3,
  parameter int TW        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_hs,
  input  logic [1:0] hs_type,
  input  logic       req_cfg,
  input  logic [1:0] cfg_sel,
  input  logic [3:0] cfg_data,
  output logic       tx_fs,
  input  logic       tx_fd,
  output logic [3:0] tx_btype,
  output logic [3:0] tx_didx,
  output logic [3:0] tx_freq,
  output logic [3:0] tx_ddidx,
  input  logic       rx_fs,
  output logic       rx_fd,
  input  logic [3:0] rx_btype,
  output logic       hs_done,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic       unsol,
  output logic       busy
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  com_state_e    r_state;
  logic          r_is_cfg;
  logic [1:0]    r_hs_type;
  logic [1:0]    r_cfg_sel;
  logic [3:0]    r_cfg_data;
  logic [RW-1:0] r_retry;
  logic          r_tmo;
  logic [3:0]    r_rx_code;
  logic          r_tx_fs, r_rx_fd, r_busy;
  logic [3:0]    r_tx_btype, r_tx_didx, r_tx_freq, r_tx_ddidx;
  logic          r_hs_done, r_cfg_done, r_cfg_err, r_unsol;
  logic          w_hit;

  com_tmo_cnt #(.TW(TW), .TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == ST_SEND),
    .i_en  (r_state == ST_WAIT),
    .o_hit (w_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_is_cfg   <= 1'b0;
      r_hs_type  <= '0;
      r_cfg_sel  <= '0;
      r_cfg_data <= '0;
      r_retry    <= '0;
      r_tmo      <= 1'b0;
      r_rx_code  <= BAG_INIT;
      r_tx_fs    <= 1'b0;
      r_rx_fd    <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_btype <= BAG_INIT;
      r_tx_didx  <= '0;
      r_tx_freq  <= '0;
      r_tx_ddidx <= '0;
      r_hs_done  <= 1'b0;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_unsol    <= 1'b0;
    end else begin
      r_hs_done  <= 1'b0;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_unsol    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_fs) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
          end else if (req_hs) begin
            r_is_cfg  <= 1'b0;
            r_hs_type <= hs_type;
            r_state   <= ST_PREP;
            r_busy    <= 1'b1;
          end else if (req_cfg) begin
            r_is_cfg   <= 1'b1;
            r_cfg_sel  <= cfg_sel;
            r_cfg_data <= cfg_data;
            r_retry    <= '0;
            r_state    <= ST_PREP;
            r_busy     <= 1'b1;
          end
        end
        ST_PREP: begin
          if (r_is_cfg) begin
            r_tx_btype <= cfg_bag(r_cfg_sel);
            case (r_cfg_sel)
              CFG_DIDX:   r_tx_didx  <= r_cfg_data;
              CFG_DPARAM: r_tx_freq  <= r_cfg_data;
              default:    r_tx_ddidx <= r_cfg_data;
            endcase
          end else begin
            r_tx_btype <= hs_bag(r_hs_type);
          end
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          // tx_fs rises one cycle after PREP so tx_btype is already settled
          if (!r_tx_fs) begin
            r_tx_fs <= 1'b1;
          end else if (tx_fd) begin
            r_tx_fs <= 1'b0;
            if (r_is_cfg) begin
              r_state <= ST_WAIT;
            end else begin
              r_hs_done <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (rx_fs) begin
            r_tmo   <= 1'b0;
            r_state <= ST_READ;
          end else if (w_hit) begin
            r_tmo   <= 1'b1;
            r_state <= ST_EVAL;
          end
        end
        ST_READ: begin
          if (rx_fs) begin
            r_rx_fd <= 1'b1;
          end else begin
            r_rx_fd   <= 1'b0;
            r_rx_code <= rx_btype;
            r_state   <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (!r_tmo && r_rx_code == BAG_ACK) begin
            r_cfg_done <= 1'b1;
            r_state    <= ST_DONE;
          end else if (r_retry < RW'(MAX_RETRY)) begin
            r_retry <= r_retry + 1'b1;
            r_state <= ST_PREP;
          end else begin
            r_cfg_err <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (rx_fs) begin
            r_rx_fd <= 1'b1;
          end else begin
            r_rx_fd <= 1'b0;
            r_unsol <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_fs    = r_tx_fs;
  assign rx_fd    = r_rx_fd;
  assign busy     = r_busy;
  assign tx_btype = r_tx_btype;
  assign tx_didx  = r_tx_didx;
  assign tx_freq  = r_tx_freq;
  assign tx_ddidx = r_tx_ddidx;
  assign hs_done  = r_hs_done;
  assign cfg_done = r_cfg_done;
  assign cfg_err  = r_cfg_err;
  assign unsol    = r_unsol;

endmodule

// File: tb/tb_com_tx_arb.sv
// Scoreboard bench for com_tx_arb: expected packets and status pulses are
// queued when requests are driven and checked as the DUT emits them.
`timescale 1ns/1ps
module tb_com_tx_arb;

  localparam int TIMEOUT   = 1000;
  localparam int MAX_RETRY = 3;
  localparam int TW        = 16;

  localparam logic [3:0] P_HS    = 4'b1000;
  localparam logic [3:0] P_CDONE = 4'b0100;
  localparam logic [3:0] P_CERR  = 4'b0010;
  localparam logic [3:0] P_UNSOL = 4'b0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_hs = 1'b0;
  logic [1:0] hs_type = 2'd0;
  logic       req_cfg = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [3:0] cfg_data = 4'd0;
  logic       tx_fd = 1'b0;
  logic       rx_fs = 1'b0;
  logic [3:0] rx_btype = 4'd0;
  logic       tx_fs, rx_fd, hs_done, cfg_done, cfg_err, unsol, busy;
  logic [3:0] tx_btype, tx_didx, tx_freq, tx_ddidx;

  com_tx_arb #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .req_hs(req_hs), .hs_type(hs_type),
    .req_cfg(req_cfg), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .tx_fs(tx_fs), .tx_fd(tx_fd), .tx_btype(tx_btype),
    .tx_didx(tx_didx), .tx_freq(tx_freq), .tx_ddidx(tx_ddidx),
    .rx_fs(rx_fs), .rx_fd(rx_fd), .rx_btype(rx_btype),
    .hs_done(hs_done), .cfg_done(cfg_done), .cfg_err(cfg_err), .unsol(unsol),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] sb_q[$];
  bit          auto_fd = 1'b1;
  bit          overlap = 1'b0;
  logic        prev_fs = 1'b0;
  logic [3:0]  m_didx = 4'd0, m_freq = 4'd0, m_ddidx = 4'd0;
  int          gap;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [23:0] obs);
    if (sb_q.size() == 0) chk("sb_unexpected", {8'h0, obs}, 32'h0);
    else                  chk(tag, {8'h0, obs}, {8'h0, sb_q.pop_front()});
  endtask

  // Monitor: every tx_fs rise and every status pulse is an output event.
  always @(negedge clk) begin
    logic [3:0] pl;
    pl = {hs_done, cfg_done, cfg_err, unsol};
    if (tx_fs && rx_fd) overlap = 1'b1;
    if (tx_fs && !prev_fs) sb_pop("sb_tx", {4'h1, 4'h0, tx_btype, tx_didx, tx_freq, tx_ddidx});
    if (pl != 4'h0) sb_pop("sb_pulse", {4'h2, 16'h0, pl});
    prev_fs = tx_fs;
  end

  // com_tx model: finishes each packet two cycles after tx_fs is seen.
  initial forever begin
    @(negedge clk);
    if (auto_fd && tx_fs) begin
      repeat (2) @(negedge clk);
      tx_fd = 1'b1;
      @(negedge clk);
      tx_fd = 1'b0;
      for (int i = 0; i < 10 && tx_fs; i++) @(negedge clk);
    end
  end

  task automatic exp_pulse(input logic [3:0] p);
    sb_q.push_back({4'h2, 16'h0, p});
  endtask

  task automatic exp_hs(input logic [1:0] t);
    logic [3:0] b;
    b = (t == 2'd1) ? 4'b0001 : (t == 2'd2) ? 4'b0010 : 4'b0011;
    sb_q.push_back({4'h1, 4'h0, b, m_didx, m_freq, m_ddidx});
  endtask

  task automatic exp_cfg(input logic [1:0] sel, input logic [3:0] d);
    logic [3:0] b;
    case (sel)
      2'd0:    begin m_didx  = d; b = 4'b0101; end
      2'd1:    begin m_freq  = d; b = 4'b0110; end
      default: begin m_ddidx = d; b = 4'b0111; end
    endcase
    sb_q.push_back({4'h1, 4'h0, b, m_didx, m_freq, m_ddidx});
  endtask

  task automatic wait_fs(input logic v, input string tag);
    for (int i = 0; i < 2000 && tx_fs !== v; i++) @(negedge clk);
    if (tx_fs !== v) chk(tag, {31'h0, tx_fs}, {31'h0, v});
  endtask

  task automatic wait_sent();
    wait_fs(1'b1, "tx_start_timeout");
    wait_fs(1'b0, "tx_end_timeout");
  endtask

  task automatic wait_pulse(input string tag);
    @(negedge clk);
    for (int i = 0; i < 3000 && {hs_done, cfg_done, cfg_err, unsol} == 4'h0; i++) @(negedge clk);
    if ({hs_done, cfg_done, cfg_err, unsol} == 4'h0) chk(tag, 32'h0, 32'h1);
  endtask

  task automatic reply(input logic [3:0] code);
    repeat (2) @(negedge clk);
    rx_btype = code;
    rx_fs    = 1'b1;
    for (int i = 0; i < 20 && !rx_fd; i++) @(negedge clk);
    if (!rx_fd) chk("rx_fd_rise_timeout", {31'h0, rx_fd}, 32'h1);
    rx_fs = 1'b0;
  endtask

  task automatic do_hs(input logic [1:0] t);
    exp_hs(t);
    exp_pulse(P_HS);
    req_hs  = 1'b1;
    hs_type = t;
    wait_pulse("hs_pulse_timeout");
    req_hs = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {tx_fs, rx_fd, busy, hs_done, cfg_done, cfg_err, unsol}, 7'h0);
    chk("rst_btype", tx_btype, 4'b0000);
    chk("rst_payload", {tx_didx, tx_freq, tx_ddidx}, 12'h0);
    rst = 1'b1;
    @(negedge clk);

    // ACK handshake with latency checks
    exp_hs(2'd1);
    exp_pulse(P_HS);
    req_hs = 1'b1; hs_type = 2'd1;
    @(negedge clk);
    chk("lat_prep_busy", {busy, tx_fs}, 2'b10);
    @(negedge clk);
    chk("lat_btype_before_fs", {tx_fs, tx_btype}, {1'b0, 4'b0001});
    hs_type = 2'd2;
    @(negedge clk);
    chk("lat_fs_n2", tx_fs, 1'b1);
    wait_fs(1'b0, "hs_send_timeout");
    chk("hs_done_after_send", hs_done, 1'b1);
    req_hs = 1'b0;
    @(negedge clk);
    chk("hs_idle_busy", busy, 1'b0);

    for (int t = 0; t < 4; t++) do_hs(2'(t));

    // DPARAM with ACK reply
    exp_cfg(2'd1, 4'd3);
    exp_pulse(P_CDONE);
    req_cfg = 1'b1; cfg_sel = 2'd1; cfg_data = 4'd3;
    wait_sent();
    reply(4'b0001);
    chk("rx_fd_while_fs", rx_fd, 1'b1);
    @(negedge clk);
    chk("rx_fd_drop", rx_fd, 1'b0);
    wait_pulse("dparam_pulse_timeout");
    req_cfg = 1'b0;

    // DIDX NAK on every attempt
    for (int i = 0; i <= MAX_RETRY; i++) exp_cfg(2'd0, 4'd5);
    exp_pulse(P_CERR);
    req_cfg = 1'b1; cfg_sel = 2'd0; cfg_data = 4'd5;
    for (int i = 0; i <= MAX_RETRY; i++) begin
      wait_sent();
      cfg_sel = 2'd2; cfg_data = 4'hF;
      reply(4'b0010);
    end
    wait_pulse("nak_pulse_timeout");
    req_cfg = 1'b0;

    // DDIDX timeout then ACK
    exp_cfg(2'd2, 4'hA);
    exp_cfg(2'd2, 4'hA);
    exp_pulse(P_CDONE);
    req_cfg = 1'b1; cfg_sel = 2'd2; cfg_data = 4'hA;
    wait_sent();
    gap = 1;
    while (!tx_fs && gap < 1100) begin
      @(negedge clk);
      if (!tx_fs) gap++;
    end
    // WAIT cycles + EVAL + PREP + first SEND cycle
    chk("tmo_gap", gap, TIMEOUT + 3);
    wait_fs(1'b0, "tmo_resend_timeout");
    reply(4'b0001);
    wait_pulse("tmo_pulse_timeout");
    req_cfg = 1'b0;
    chk("tmo_ddidx", tx_ddidx, 4'hA);

    // Simultaneous requests: handshake first
    exp_hs(2'd3);
    exp_pulse(P_HS);
    exp_cfg(2'd0, 4'd6);
    exp_pulse(P_CDONE);
    req_hs = 1'b1; hs_type = 2'd3;
    req_cfg = 1'b1; cfg_sel = 2'd0; cfg_data = 4'd6;
    wait_pulse("sim_hs_timeout");
    req_hs = 1'b0;
    wait_sent();
    reply(4'b0001);
    wait_pulse("sim_cfg_timeout");
    req_cfg = 1'b0;

    // Unsolicited packet preempts both requests
    exp_pulse(P_UNSOL);
    exp_hs(2'd1);
    exp_pulse(P_HS);
    exp_cfg(2'd1, 4'd7);
    exp_pulse(P_CDONE);
    rx_btype = 4'b0011; rx_fs = 1'b1;
    req_hs = 1'b1; hs_type = 2'd1;
    req_cfg = 1'b1; cfg_sel = 2'd1; cfg_data = 4'd7;
    for (int i = 0; i < 20 && !rx_fd; i++) @(negedge clk);
    chk("drain_rx_fd", rx_fd, 1'b1);
    rx_fs = 1'b0;
    wait_pulse("unsol_timeout");
    wait_pulse("pre_hs_timeout");
    req_hs = 1'b0;
    wait_sent();
    reply(4'b0001);
    wait_pulse("pre_cfg_timeout");
    req_cfg = 1'b0;

    // Reset during SEND
    auto_fd = 1'b0;
    exp_hs(2'd1);
    req_hs = 1'b1; hs_type = 2'd1;
    wait_fs(1'b1, "rst_send_timeout");
    @(negedge clk);
    rst = 1'b0; req_hs = 1'b0;
    #1;
    chk("rst_send_outs", {tx_fs, busy, rx_fd}, 3'b000);
    chk("rst_send_btype", tx_btype, 4'b0000);
    m_didx = 4'd0; m_freq = 4'd0; m_ddidx = 4'd0;
    chk("rst_send_payload", {tx_didx, tx_freq, tx_ddidx}, 12'h0);
    @(negedge clk);
    rst = 1'b1; auto_fd = 1'b1;
    repeat (5) @(negedge clk);

    // Reset during WAIT
    exp_cfg(2'd1, 4'd9);
    req_cfg = 1'b1; cfg_sel = 2'd1; cfg_data = 4'd9;
    wait_sent();
    repeat (10) @(negedge clk);
    rst = 1'b0; req_cfg = 1'b0;
    #1;
    chk("rst_wait_outs", {tx_fs, busy, rx_fd}, 3'b000);
    chk("rst_wait_fields", {tx_btype, tx_freq}, 8'h00);
    m_freq = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (1100) @(negedge clk);

    do_hs(2'd2);
    exp_cfg(2'd0, 4'd4);
    exp_pulse(P_CDONE);
    req_cfg = 1'b1; cfg_sel = 2'd0; cfg_data = 4'd4;
    wait_sent();
    reply(4'b0001);
    wait_pulse("post_rst_cfg_timeout");
    req_cfg = 1'b0;

    repeat (5) @(negedge clk);
    chk("fs_fd_exclusive", {31'h0, overlap}, 32'h0);
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/com_tx_arb.md
# com_tx_arb

Transmit scheduler for the `com_tx` serializer; all interfaces run in one clock domain.
- Arbitrates between two requesters: a handshake responder (ACK/NAK/STALL) and a configuration requester (DIDX/DPARAM/DDIDX).
- Drives the `com_tx` fs/fd handshake and collects the peer's reply through the `typec_rx` fs/fd handshake.
- Retries configuration packets on NAK or timeout.

## Interface
- `TIMEOUT`, 1000: clk cycles to wait for a reply after a cfg packet.
- `MAX_RETRY`, 3: resends after the first attempt before `cfg_err`.
- `TW`, 16: timeout counter width; must satisfy TIMEOUT < 2^TW.
- `clk`  in  1  block clock (all logic).
- `rst`  in  1  reset, asynchronous, active-low.
- `req_hs`  in  1  handshake send request (level, held until `hs_done`).
- `hs_type`  in  2  1=ACK, 2=NAK, 3=STALL; 0 is illegal and is sent as STALL.
- `req_cfg`  in  1  config send request (level, held until `cfg_done`/`cfg_err`).
- `cfg_sel`  in  2  0=DIDX, 1=DPARAM, 2=DDIDX; 3 is illegal and is sent as DDIDX.
- `cfg_data`  in  4  payload for the selected config.
- `tx_fs`  out 1  start to `com_tx`.
- `tx_fd`  in  1  `com_tx` finished.
- `tx_btype`  out 4  BAG code to `com_tx`.
- `tx_didx` / `tx_freq` / `tx_ddidx`  out 4 each  payload fields.
- `rx_fs`  in  1  `typec_rx` packet available.
- `rx_fd`  out 1  packet consumed.
- `rx_btype`  in  4  received BAG code.
- `hs_done`, `cfg_done`, `cfg_err`, `unsol`  out 1 each  one-cycle status pulses.
- `busy`  out 1  high in every state except IDLE.

## Operation
- **States:** IDLE, PREP, SEND, WAIT, READ, EVAL, DRAIN, DONE.
- **IDLE, priority order:**
  1. `rx_fs` goes to DRAIN.
  2. `req_hs` latches `hs_type` and goes to PREP.
  3. `req_cfg` latches `cfg_sel`/`cfg_data`, clears retry count and goes to PREP.
- **PREP:** registers `tx_btype` and the payload. Only the selected payload field is updated; the others hold. Next state is SEND.
- **SEND:** `tx_fs`=1 until `tx_fd`=1.
  - Handshake packet: next state is DONE (no reply expected).
  - Cfg packet: clear the timeout counter; next state is WAIT.
- **WAIT:** counter increments each cycle.
  - `rx_fs`=1 goes to READ and takes precedence over timeout in the same cycle.
  - Counter reaching TIMEOUT−1 goes to EVAL with result=timeout.
- **READ:** `rx_fd`=1 while `rx_fs`=1. On `rx_fs`=0, latch `rx_btype` and go to EVAL.
- **EVAL:**
  - ACK → DONE with `cfg_done`.
  - NAK, STALL, timeout or any other code: if retry < MAX_RETRY, increment retry and go to PREP (resend); else go to DONE with `cfg_err`.
- **DRAIN:** `rx_fd`=1 until `rx_fs`=0, then go to DONE with `unsol`.
- **DONE:** exactly one of the four status pulses is high for one cycle; next state is IDLE.
  - The requester drops its `req_*` on the edge at which it sees its pulse.
  - IDLE therefore never regrants the same request.
- **BAG codes:** INIT=0000, ACK=0001, NAK=0010, STALL=0011, DIDX=0101, DPARAM=0110, DDIDX=0111.

## Timing
- **Reset values:** state IDLE, `tx_btype`=BAG_INIT, all payload fields 0. All single-bit outputs are 0: `tx_fs`, `rx_fd`, `busy` and the four pulses.
- **Latency:** a request sampled in IDLE at edge N gives PREP at N+1 and `tx_fs` high from N+2. `tx_btype` is stable before `tx_fs` rises and through SEND.
- `tx_fs` drops the cycle after `tx_fd` is sampled high. `tx_fs` and `rx_fd` are never high together.
- **Reply timeout:** exactly TIMEOUT cycles in WAIT, then one EVAL cycle.
- **Handshake with no reply:** `hs_done` at SEND-exit+1.
- **Simultaneous `req_hs` and `req_cfg`:** `req_hs` is served first; `req_cfg` is granted on the next IDLE.
- Requests raised while busy wait; no request is dropped.
- **`rst` low mid-operation:** all state and outputs return to reset values immediately. No status pulse is issued for the aborted transfer.
- Changes to `req_*` arguments after grant are ignored.

## Structure
- **Shared package `com_pkg`:** BAG_* codes, state encodings, `hs_type` and `cfg_sel` constants. Shared with `com_tx` and `typec_rx`.
- **Sub-module `com_tmo_cnt`:** TW-bit clear/enable counter with a `hit` output at TIMEOUT−1.
- All FSM, arbitration and retry logic stays in `com_tx_arb`.

## Test plan
- **ACK send:** `req_hs`=1, `hs_type`=1 → `tx_btype`=0001 with `tx_fs` 2 cycles later; `tx_fd` pulse → `hs_done` one cycle after SEND exit, `busy`=0.
- **DPARAM, ACK reply:** `req_cfg`, `cfg_sel`=1, `cfg_data`=3; reply 0001 → `tx_btype`=0110, `tx_freq`=3, `rx_fd` high until `rx_fs` falls, `cfg_done`.
- **DIDX, NAK ×4:** `cfg_sel`=0, `cfg_data`=5; reply 0010 every time, MAX_RETRY=3 → four transmissions, then `cfg_err`; no `cfg_done`.
- **DDIDX timeout then ACK:** `cfg_sel`=2, `cfg_data`=A; no reply → WAIT lasts exactly 1000 cycles, resend, ACK → `cfg_done`, `tx_ddidx`=A.
- **Simultaneous requests:** `req_hs` (STALL) and `req_cfg` (DIDX) in the same cycle → 0011 sent first, `hs_done`, then 0101 sent; `rx_fs` in IDLE gives DRAIN with `unsol` and preempts both.
- **Reset mid-operation:** `rst`=0 during SEND and again during WAIT → `tx_fs`=0, `tx_btype`=0000, no pulses; after release a fresh request completes normally.
